// File: rtl/aes_axis_block_tx.sv
// aes_axis_block_tx: buffers whole AES result blocks and streams each one as WORD_S-bit AXI4-Stream beats.
module aes_axis_block_tx #(
   parameter int BLK_S      = 128,
   parameter int WORD_S     = 32,
   parameter int FIFO_DEPTH = 2,
   parameter bit SWAP_BYTES = 1'b1
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [BLK_S-1:0]  blk_in,
   input  logic              blk_last,
   input  logic              blk_valid,
   output logic              blk_ready,
   output logic [WORD_S-1:0] m00_axis_tdata,
   output logic              m00_axis_tvalid,
   input  logic              m00_axis_tready,
   output logic              m00_axis_tlast,
   output logic              busy,
   output logic              blk_sent
);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int NBEAT = BLK_S / WORD_S;
   localparam int BW    = $clog2(NBEAT);
   localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);
   localparam logic [AW:0]   ONE_BLK   = 1;

   typedef enum logic {IDLE, SEND} state_t;

   logic [BLK_S-1:0]  mem_data [FIFO_DEPTH];
   logic              mem_last [FIFO_DEPTH];
   state_t            state_q, state_d;
   logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
   logic [AW-1:0]     nxt_idx;
   logic [BW-1:0]     beat_q, beat_d, beat_nx;
   logic [WORD_S-1:0] tdata_q, tdata_d;
   logic              tvalid_q, tvalid_d, tlast_q, tlast_d, sent_q, sent_d, rdy_en_q;
   logic              empty, full, push, hs, pop, head_last;
   logic [BLK_S-1:0]  head_blk;

   function automatic logic [WORD_S-1:0] beat_word(input logic [BLK_S-1:0] blk, input logic [BW-1:0] k);
      logic [WORD_S-1:0] w;
      w = '0;
      for (int i = 0; i < WORD_S / 8; i++)
         w[8*i +: 8] = SWAP_BYTES ? blk[int'(k)*WORD_S + 8*i +: 8]
                                  : blk[int'(k)*WORD_S + WORD_S - 8 - 8*i +: 8];
      return w;
   endfunction

   assign empty     = wr_ptr_q == rd_ptr_q;
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count     = wr_ptr_q - rd_ptr_q;
   assign blk_ready = rdy_en_q && !full;
   assign push      = blk_valid && blk_ready;
   assign hs        = tvalid_q && m00_axis_tready;
   assign pop       = hs && beat_q == LAST_BEAT;
   assign beat_nx   = beat_q + 1'b1;
   assign nxt_idx   = rd_ptr_q[AW-1:0] + 1'b1;
   assign head_blk  = mem_data[rd_ptr_q[AW-1:0]];
   assign head_last = mem_last[rd_ptr_q[AW-1:0]];

   // The head block stays in the FIFO until its final beat handshakes; the next one is read one slot ahead.
   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      tlast_d  = tlast_q;
      sent_d   = pop;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      if (state_q == IDLE) begin
         if (!empty) begin
            state_d  = SEND;
            beat_d   = '0;
            tvalid_d = 1'b1;
            tdata_d  = beat_word(head_blk, '0);
            tlast_d  = 1'b0;
         end
      end else if (pop) begin
         beat_d  = '0;
         tlast_d = 1'b0;
         if (count > ONE_BLK) begin
            tdata_d = beat_word(mem_data[nxt_idx], '0);
         end else begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
         end
      end else if (hs) begin
         beat_d  = beat_nx;
         tdata_d = beat_word(head_blk, beat_nx);
         tlast_d = head_last && beat_nx == LAST_BEAT;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tlast_q  <= 1'b0;
         sent_q   <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         tlast_q  <= tlast_d;
         sent_q   <= sent_d;
         rdy_en_q <= 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (push) begin
         mem_data[wr_ptr_q[AW-1:0]] <= blk_in;
         mem_last[wr_ptr_q[AW-1:0]] <= blk_last;
      end
   end

   assign m00_axis_tdata  = tdata_q;
   assign m00_axis_tvalid = tvalid_q;
   assign m00_axis_tlast  = tlast_q;
   assign blk_sent        = sent_q;
   assign busy            = !empty || tvalid_q;
endmodule

// File: tb/tb_aes_axis_block_tx.sv
// tb_aes_axis_block_tx: drives little- and big-endian instances with shared stimulus and
// compares every beat against a queue of expected beats built from the pushed blocks.
module tb_aes_axis_block_tx;
   localparam int DEPTH = 2;

   logic         aclk = 1'b0, aresetn = 1'b0, blk_last = 1'b0, blk_valid = 1'b0, tready = 1'b0;
   logic [127:0] blk_in = '0;
   logic         m_ready, m_tvalid, m_tlast, m_busy, m_sent;
   logic         s_ready, s_tvalid, s_tlast, s_busy, s_sent;
   logic [31:0]  m_tdata, s_tdata;
   int           errors = 0, checks = 0;

   aes_axis_block_tx #(.FIFO_DEPTH(DEPTH), .SWAP_BYTES(1'b1)) u_le (
      .aclk(aclk), .aresetn(aresetn), .blk_in(blk_in), .blk_last(blk_last), .blk_valid(blk_valid),
      .blk_ready(m_ready), .m00_axis_tdata(m_tdata), .m00_axis_tvalid(m_tvalid),
      .m00_axis_tready(tready), .m00_axis_tlast(m_tlast), .busy(m_busy), .blk_sent(m_sent));

   aes_axis_block_tx #(.FIFO_DEPTH(DEPTH), .SWAP_BYTES(1'b0)) u_be (
      .aclk(aclk), .aresetn(aresetn), .blk_in(blk_in), .blk_last(blk_last), .blk_valid(blk_valid),
      .blk_ready(s_ready), .m00_axis_tdata(s_tdata), .m00_axis_tvalid(s_tvalid),
      .m00_axis_tready(tready), .m00_axis_tlast(s_tlast), .busy(s_busy), .blk_sent(s_sent));

   always #5 aclk = ~aclk;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   typedef struct packed {
      logic [31:0] le;
      logic [31:0] be;
      logic        last;
      logic        endb;
   } beat_t;

   function automatic beat_t mk(input logic [127:0] blk, input logic l, input int k);
      logic [7:0] bt [16];
      beat_t r;
      for (int i = 0; i < 16; i++) bt[i] = blk[8*i +: 8];
      r.le   = {bt[4*k+3], bt[4*k+2], bt[4*k+1], bt[4*k]};
      r.be   = {bt[4*k], bt[4*k+1], bt[4*k+2], bt[4*k+3]};
      r.last = l && k == 3;
      r.endb = k == 3;
      return r;
   endfunction

   beat_t       q[$];
   beat_t       b;
   int          nb, hs_cnt = 0, tlast_cnt = 0;
   logic        sent_exp = 1'b0, fresh = 1'b0, stall = 1'b0, rdy_ok = 1'b0, p_last = 1'b0;
   logic [31:0] p_m = '0, p_s = '0;

   always @(posedge aclk or negedge aresetn) rdy_ok <= aresetn;

   // Reference model: remaining beats of every buffered block; a block occupies a slot until its last beat goes.
   always @(negedge aclk) begin
      if (!aresetn) begin
         q.delete();
         sent_exp = 1'b0;
         fresh    = 1'b0;
         stall    = 1'b0;
      end else begin
         nb = (q.size() + 3) / 4;
         chk(m_tvalid == (nb > 0 && !fresh), "tvalid_le", m_tvalid, nb > 0 && !fresh);
         chk(s_tvalid == (nb > 0 && !fresh), "tvalid_be", s_tvalid, nb > 0 && !fresh);
         chk(m_busy == (nb > 0) && s_busy == (nb > 0), "busy", {m_busy, s_busy}, nb > 0);
         chk(m_ready == (rdy_ok && nb < DEPTH), "blk_ready_le", m_ready, rdy_ok && nb < DEPTH);
         chk(s_ready == (rdy_ok && nb < DEPTH), "blk_ready_be", s_ready, rdy_ok && nb < DEPTH);
         chk(m_sent == sent_exp && s_sent == sent_exp, "blk_sent", {m_sent, s_sent}, sent_exp);
         if (stall) chk(m_tdata == p_m && s_tdata == p_s && m_tlast == p_last, "stall_stable",
                        {m_tdata, s_tdata}, {p_m, p_s});
         stall    = m_tvalid && !tready;
         p_m      = m_tdata;
         p_s      = s_tdata;
         p_last   = m_tlast;
         sent_exp = 1'b0;
         if (m_tvalid && tready) begin
            hs_cnt++;
            chk(q.size() != 0, "beat_expected", q.size(), 1);
            if (q.size() != 0) begin
               b = q.pop_front();
               chk(m_tdata == b.le, "tdata_le", m_tdata, b.le);
               chk(s_tdata == b.be, "tdata_be", s_tdata, b.be);
               chk(m_tlast == b.last && s_tlast == b.last, "tlast", {m_tlast, s_tlast}, b.last);
               if (m_tlast) tlast_cnt++;
               sent_exp = b.endb;
            end
         end
         fresh = 1'b0;
         if (blk_valid && m_ready) begin
            fresh = q.size() == 0;
            for (int k = 0; k < 4; k++) q.push_back(mk(blk_in, blk_last, k));
         end
      end
   end

   logic drv_stop = 1'b0;
   int   phase = 0;

   task automatic ready_drv(input int mode);
      while (!drv_stop) begin
         @(posedge aclk);
         #1;
         tready = mode == 1 ? phase < 6 : $urandom_range(0, 1) == 1;
         phase  = (phase + 1) % 8;
      end
   endtask

   task automatic push(input logic [127:0] d, input logic l);
      bit ok;
      ok        = 1'b0;
      blk_in    = d;
      blk_last  = l;
      blk_valid = 1'b1;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge aclk);
         ok = m_ready;
         @(posedge aclk);
         #1;
      end
      blk_valid = 1'b0;
      if (!ok) chk(1'b0, "push_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2000; i++) begin
         @(negedge aclk);
         if (!m_busy) break;
      end
      chk(!m_busy, "drain_timeout", m_busy, 0);
   endtask

   function automatic logic [127:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   typedef struct packed {
      logic [127:0]     blk;
      logic             last;
      logic [3:0][31:0] le;
      logic [3:0][31:0] be;
   } vec_t;

   vec_t vecs [3];

   initial begin
      int h0, l0, nl;
      logic [127:0] blk_b;
      logic lb;
      vecs[0] = {128'h5ac5b47080b7cdd830047b6ad8e0c469, 1'b1,
                 {32'h5ac5b470, 32'h80b7cdd8, 32'h30047b6a, 32'hd8e0c469},
                 {32'h70b4c55a, 32'hd8cdb780, 32'h6a7b0430, 32'h69c4e0d8}};
      vecs[1] = {128'h0f0e0d0c0b0a09080706050403020100, 1'b0,
                 {32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100},
                 {32'h0c0d0e0f, 32'h08090a0b, 32'h04050607, 32'h00010203}};
      vecs[2] = {128'hffeeddccbbaa99887766554433221100, 1'b1,
                 {32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100},
                 {32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233}};

      repeat (2) @(posedge aclk);
      @(negedge aclk);
      chk(m_tvalid == 1'b0 && s_tvalid == 1'b0, "rst_tvalid", m_tvalid, 0);
      chk(m_tdata == '0 && s_tdata == '0, "rst_tdata", m_tdata, 0);
      chk(m_tlast == 1'b0 && m_busy == 1'b0 && m_sent == 1'b0, "rst_flags", {m_tlast, m_busy, m_sent}, 0);
      @(posedge aclk);
      #1 aresetn = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      chk(m_ready == 1'b1, "ready_after_release", m_ready, 1);

      // Known vectors, both byte orders, exact cycle timing with tready high
      for (int i = 0; i < 3; i++) begin
         @(posedge aclk);
         #1;
         tready    = 1'b1;
         blk_in    = vecs[i].blk;
         blk_last  = vecs[i].last;
         blk_valid = 1'b1;
         @(posedge aclk);
         #1 blk_valid = 1'b0;
         @(negedge aclk);
         chk(m_tvalid == 1'b0, "latency_gap", m_tvalid, 0);
         for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            chk(m_tvalid == 1'b1, "vec_tvalid", m_tvalid, 1);
            chk(m_tdata == vecs[i].le[k], "vec_le", m_tdata, vecs[i].le[k]);
            chk(s_tdata == vecs[i].be[k], "vec_be", s_tdata, vecs[i].be[k]);
            chk(m_tlast == (vecs[i].last && k == 3), "vec_tlast", m_tlast, vecs[i].last && k == 3);
         end
         @(negedge aclk);
         chk(m_sent == 1'b1 && m_tvalid == 1'b0, "vec_sent", {m_sent, m_tvalid}, 2'b10);
         @(negedge aclk);
         chk(m_sent == 1'b0, "vec_sent_pulse", m_sent, 0);
      end

      // 6-high/2-low ready pattern over 8 blocks
      @(posedge aclk);
      #1;
      h0 = hs_cnt;
      l0 = tlast_cnt;
      drv_stop = 1'b0;
      phase = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) push(rnd(), i == 7);
            wait_idle();
            drv_stop = 1'b1;
         end
         ready_drv(1);
      join
      tready = 1'b1;
      chk(hs_cnt - h0 == 32, "pattern_beats", hs_cnt - h0, 32);
      chk(tlast_cnt - l0 == 1, "pattern_tlast", tlast_cnt - l0, 1);

      // Full buffer under stalled output, then release with no inter-block gap
      tready = 1'b0;
      push(rnd(), 1'b0);
      blk_b = rnd();
      push(blk_b, 1'b0);
      @(negedge aclk);
      chk(m_ready == 1'b0, "full_ready", m_ready, 0);
      @(posedge aclk);
      #1;
      tready    = 1'b1;
      blk_in    = rnd();
      blk_last  = 1'b1;
      blk_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge aclk);
         chk(m_ready == 1'b0, "full_hold", m_ready, 0);
      end
      @(negedge aclk);
      chk(m_ready == 1'b1, "pop_frees_slot", m_ready, 1);
      chk(m_tvalid == 1'b1 && m_tdata == blk_b[31:0], "no_gap", m_tdata, blk_b[31:0]);
      @(posedge aclk);
      #1 blk_valid = 1'b0;
      wait_idle();

      // Reset in the middle of a two-block request
      @(posedge aclk);
      #1;
      push(rnd(), 1'b0);
      push(rnd(), 1'b1);
      @(posedge aclk);
      @(posedge aclk);
      #3 aresetn = 1'b0;
      #1;
      chk(m_tvalid == 1'b0 && s_tvalid == 1'b0, "mid_rst_tvalid", m_tvalid, 0);
      chk(m_busy == 1'b0 && m_tdata == '0, "mid_rst_busy", {m_busy, m_tdata}, 0);
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      @(posedge aclk);
      #1;
      h0 = hs_cnt;
      l0 = tlast_cnt;
      push(rnd(), 1'b1);
      wait_idle();
      chk(hs_cnt - h0 == 4, "post_rst_beats", hs_cnt - h0, 4);
      chk(tlast_cnt - l0 == 1, "post_rst_tlast", tlast_cnt - l0, 1);

      // Back-to-back pushes keeping the buffer full, random blk_last
      @(posedge aclk);
      #1;
      h0 = hs_cnt;
      l0 = tlast_cnt;
      nl = 0;
      for (int i = 0; i < 16; i++) begin
         lb = $urandom_range(0, 1) == 1;
         nl += int'(lb);
         push(rnd(), lb);
      end
      wait_idle();
      chk(hs_cnt - h0 == 64, "b2b_beats", hs_cnt - h0, 64);
      chk(tlast_cnt - l0 == nl, "b2b_tlast", tlast_cnt - l0, nl);

      // Random ready and random push gaps
      @(posedge aclk);
      #1;
      h0 = hs_cnt;
      l0 = tlast_cnt;
      nl = 0;
      drv_stop = 1'b0;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               repeat ($urandom_range(0, 3)) begin
                  @(posedge aclk);
                  #1;
               end
               lb = $urandom_range(0, 1) == 1;
               nl += int'(lb);
               push(rnd(), lb);
            end
            wait_idle();
            drv_stop = 1'b1;
         end
         ready_drv(2);
      join
      tready = 1'b1;
      chk(hs_cnt - h0 == 80, "rand_beats", hs_cnt - h0, 80);
      chk(tlast_cnt - l0 == nl, "rand_tlast", tlast_cnt - l0, nl);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end
endmodule
